if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 79 +++++++
 tb/tb_if_fetch.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM port,
// and forwards {ce, pc} to decode. Redirects seen while stalled are parked
// and applied when the stall releases.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  output logic               fetch_adel
);

  localparam logic [31:0] PC_BEFORE_RESET = RESET_PC - 32'd4;

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        br_pend_v;
  logic [31:0] br_pend_addr;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stop;
  logic [31:0] next_pc;
  logic        pc_misaligned;

  // Only this stage's stall bit matters; the other bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:1];

  // A redirect is meaningless before the first real fetch, so gate it with ce.
  assign br_e    = br_bus[32] & ce_reg;
  assign br_addr = br_bus[31:0];
  assign stop    = stall[0];

  // Next PC: live redirect beats a parked one, which beats sequential fetch.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (br_pend_v) begin
      next_pc = br_pend_addr;
    end
  end

  // PC/ce advance when unstalled; while stalled, remember the newest redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= PC_BEFORE_RESET;
      ce_reg       <= 1'b0;
      br_pend_v    <= 1'b0;
      br_pend_addr <= 32'd0;
    end else if (!stop) begin
      pc_reg    <= next_pc;
      ce_reg    <= 1'b1;
      br_pend_v <= 1'b0;
    end else if (br_e) begin
      br_pend_v    <= 1'b1;
      br_pend_addr <= br_addr;
    end
  end

  // SRAM port and decode bus are pure functions of the registers, so they
  // stay constant for the whole of a stall.
  assign pc_misaligned   = (pc_reg[1:0] != 2'b00);
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_en    = ce_reg & ~pc_misaligned;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign fetch_adel      = ce_reg & pc_misaligned;
  assign if_to_id_bus    = {ce_reg, pc_reg};

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset release, redirects, stalled redirects,
// misaligned targets, PC wrap and asynchronous reset during a stall.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_adel;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(32'hBFC0_0000), .STALL_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .fetch_adel     (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check address, enable and address-error flag together.
  task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic en, input logic adel);
    chk({tag, ".addr"}, {32'd0, inst_sram_addr}, {32'd0, addr});
    chk({tag, ".en"},   {63'd0, inst_sram_en},   {63'd0, en});
    chk({tag, ".adel"}, {63'd0, fetch_adel},     {63'd0, adel});
    $display("step %-12s addr=%h en=%0d adel=%0d ce=%0d", tag, inst_sram_addr,
             inst_sram_en, fetch_adel, if_to_id_bus[32]);
  endtask

  initial begin
    rst_n  = 1'b0;
    stall  = 6'd0;
    br_bus = 33'd0;
    #12;
    // Reset values
    chk("rst.bus",  {31'd0, if_to_id_bus}, {31'd0, 1'b0, 32'hBFBF_FFFC});
    chk("rst.en",   {63'd0, inst_sram_en}, 64'd0);
    chk("rst.adel", {63'd0, fetch_adel},   64'd0);
    chk("rst.wen",  {60'd0, inst_sram_wen}, 64'd0);
    chk("rst.wdata",{32'd0, inst_sram_wdata}, 64'd0);
    step();
    rst_n = 1'b1;

    step(); chk_fetch("rel1", 32'hBFC0_0000, 1'b1, 1'b0);
    chk("rel1.ce", {63'd0, if_to_id_bus[32]}, 64'd1);
    step(); chk_fetch("rel2", 32'hBFC0_0004, 1'b1, 1'b0);
    step(); chk_fetch("rel3", 32'hBFC0_0008, 1'b1, 1'b0);
    step(); chk_fetch("seq4", 32'hBFC0_000C, 1'b1, 1'b0);
    step(); chk_fetch("seq5", 32'hBFC0_0010, 1'b1, 1'b0);

    // Plain redirect
    br_bus = {1'b1, 32'hBFC0_0100};
    step(); chk_fetch("br.tgt", 32'hBFC0_0100, 1'b1, 1'b0);
    br_bus = 33'd0;
    step(); chk_fetch("br.next", 32'hBFC0_0104, 1'b1, 1'b0);

    // Two redirects under a 3-cycle stall: newest wins
    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0200};
    step(); chk_fetch("stl.c1", 32'hBFC0_0104, 1'b1, 1'b0);
    br_bus = {1'b1, 32'hBFC0_0300};
    step(); chk_fetch("stl.c2", 32'hBFC0_0104, 1'b1, 1'b0);
    br_bus = 33'd0;
    step(); chk_fetch("stl.c3", 32'hBFC0_0104, 1'b1, 1'b0);
    stall = 6'd0;
    step(); chk_fetch("stl.rel", 32'hBFC0_0300, 1'b1, 1'b0);
    step(); chk_fetch("stl.clr", 32'hBFC0_0304, 1'b1, 1'b0);

    // Live redirect at release overrides the parked one
    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0200};
    step(); chk_fetch("sim.c1", 32'hBFC0_0304, 1'b1, 1'b0);
    br_bus = 33'd0;
    step(); chk_fetch("sim.c2", 32'hBFC0_0304, 1'b1, 1'b0);
    stall  = 6'd0;
    br_bus = {1'b1, 32'hBFC0_0400};
    step(); chk_fetch("sim.rel", 32'hBFC0_0400, 1'b1, 1'b0);
    br_bus = 33'd0;
    step(); chk_fetch("sim.clr", 32'hBFC0_0404, 1'b1, 1'b0);

    // Stall bits of other stages do not freeze fetch
    stall = 6'b111110;
    step(); chk_fetch("oth.stall", 32'hBFC0_0408, 1'b1, 1'b0);
    stall = 6'd0;

    // Misaligned target
    br_bus = {1'b1, 32'hBFC0_0102};
    step(); chk_fetch("mis.tgt", 32'hBFC0_0102, 1'b0, 1'b1);
    chk("mis.bus", {31'd0, if_to_id_bus}, {31'd0, 1'b1, 32'hBFC0_0102});
    br_bus = 33'd0;
    step(); chk_fetch("mis.next", 32'hBFC0_0106, 1'b0, 1'b1);
    br_bus = {1'b1, 32'hBFC0_0200};
    step(); chk_fetch("mis.fix", 32'hBFC0_0200, 1'b1, 1'b0);

    // PC adder wraps
    br_bus = {1'b1, 32'hFFFF_FFFC};
    step(); chk_fetch("wrap.top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    br_bus = 33'd0;
    step(); chk_fetch("wrap.zero", 32'h0000_0000, 1'b1, 1'b0);

    // Asynchronous reset mid-stall with a parked redirect
    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0500};
    step(); chk_fetch("ar.stall", 32'h0000_0000, 1'b1, 1'b0);
    br_bus = 33'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.bus",  {31'd0, if_to_id_bus}, {31'd0, 1'b0, 32'hBFBF_FFFC});
    chk("ar.en",   {63'd0, inst_sram_en}, 64'd0);
    chk("ar.adel", {63'd0, fetch_adel},   64'd0);
    $display("step %-12s bus=%h en=%0d", "ar.async", if_to_id_bus, inst_sram_en);
    step();
    stall  = 6'd0;
    rst_n  = 1'b1;
    // Redirect while ce is still low must be ignored
    br_bus = {1'b1, 32'hBFC0_0700};
    step(); chk_fetch("ar.rel1", 32'hBFC0_0000, 1'b1, 1'b0);
    br_bus = 33'd0;
    step(); chk_fetch("ar.rel2", 32'hBFC0_0004, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
